// File: rtl/usb_hub_pkg.sv
// Shared definitions for the USB hub downstream-port logic:
// sampled line states, port state encoding and a small line helper.
package usb_hub_pkg;

   localparam logic [1:0] LINE_SE0  = 2'b00;
   localparam logic [1:0] LINE_LS_J = 2'b01;
   localparam logic [1:0] LINE_FS_J = 2'b10;
   localparam logic [1:0] LINE_SE1  = 2'b11;

   typedef enum logic [2:0] {
      PS_DISCONNECTED = 3'd0,
      PS_DEBOUNCE     = 3'd1,
      PS_ATTACHED     = 3'd2,
      PS_PORT_RESET   = 3'd3,
      PS_RECOVERY     = 3'd4,
      PS_ENABLED      = 3'd5
   } portStateT;

   // A connect is signalled by the idle (J) level of either speed.
   function automatic logic isJState(input logic [1:0] line);
      return (line == LINE_FS_J) || (line == LINE_LS_J);
   endfunction

endpackage

// File: rtl/usb_se0_filter.sv
// Disconnect detector: flags the DISCONNECT_CYCLES-th consecutive SE0 sample,
// so shorter SE0 runs (EOPs) never reach the port FSM.
module usb_se0_filter
   import usb_hub_pkg::*;
#(
   parameter int DISCONNECT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [1:0] usb_signals,
   output logic       disconnect
);

   localparam int CNT_W = $clog2(DISCONNECT_CYCLES) + 1;
   localparam logic [CNT_W-1:0] SE0_LAST = CNT_W'(DISCONNECT_CYCLES - 1);

   logic [CNT_W-1:0] se0Count;
   logic             isSe0;

   assign isSe0 = (usb_signals == LINE_SE0);

   // The count saturates one short of the threshold; the current sample completes the run.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         se0Count <= '0;
      end else if (!enable || !isSe0) begin
         se0Count <= '0;
      end else if (se0Count != SE0_LAST) begin
         se0Count <= se0Count + 1'b1;
      end
   end

   assign disconnect = enable && isSe0 && (se0Count == SE0_LAST);

endmodule

// File: rtl/usb_port_attach_controller.sv
// Per-downstream-port attach sequencer: debounces connect, classifies speed,
// runs the timed port reset and recovery check, and tracks disconnects.
module usb_port_attach_controller
   import usb_hub_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 16,
   parameter int RESET_CYCLES      = 32,
   parameter int RECOVERY_CYCLES   = 4,
   parameter int DISCONNECT_CYCLES = 4
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] usb_signals,
   input  logic       port_enable_req,
   input  logic       port_disable_req,
   output logic       drive_se0,
   output logic       connected,
   output logic       low_speed,
   output logic       port_enabled,
   output logic       reset_done,
   output logic [2:0] port_state
);

   localparam int MAX_DR    = (DEBOUNCE_CYCLES > RESET_CYCLES) ? DEBOUNCE_CYCLES : RESET_CYCLES;
   localparam int MAX_COUNT = (MAX_DR > RECOVERY_CYCLES) ? MAX_DR : RECOVERY_CYCLES;
   localparam int CNT_W     = $clog2(MAX_COUNT) + 1;

   localparam logic [CNT_W-1:0] DEBOUNCE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] RESET_LAST    = CNT_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOVERY_LAST = CNT_W'(RECOVERY_CYCLES - 1);

   portStateT        state;
   logic [CNT_W-1:0] count;
   logic [1:0]       speedJ;
   logic             filterEnable;
   logic             disconnect;

   // The line is not watched during PORT_RESET since the hub itself is driving SE0.
   assign filterEnable = (state == PS_ATTACHED) || (state == PS_ENABLED) || (state == PS_RECOVERY);

   usb_se0_filter #(
      .DISCONNECT_CYCLES(DISCONNECT_CYCLES)
   ) se0Filter (
      .clock       (clock),
      .reset       (reset),
      .enable      (filterEnable),
      .usb_signals (usb_signals),
      .disconnect  (disconnect)
   );

   assign port_state = state;

   // Disconnect overrides every per-state decision; the counter restarts on each state change.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= PS_DISCONNECTED;
         count        <= '0;
         speedJ       <= LINE_SE0;
         drive_se0    <= 1'b0;
         connected    <= 1'b0;
         low_speed    <= 1'b0;
         port_enabled <= 1'b0;
         reset_done   <= 1'b0;
      end else begin
         reset_done <= 1'b0;
         if (disconnect) begin
            state        <= PS_DISCONNECTED;
            count        <= '0;
            speedJ       <= LINE_SE0;
            drive_se0    <= 1'b0;
            connected    <= 1'b0;
            low_speed    <= 1'b0;
            port_enabled <= 1'b0;
         end else begin
            case (state)
               PS_DISCONNECTED: begin
                  if (isJState(usb_signals)) begin
                     state  <= PS_DEBOUNCE;
                     speedJ <= usb_signals;
                     count  <= '0;
                  end
               end
               PS_DEBOUNCE: begin
                  if (usb_signals == speedJ) begin
                     if (count == DEBOUNCE_LAST) begin
                        state     <= PS_ATTACHED;
                        count     <= '0;
                        connected <= 1'b1;
                        low_speed <= (speedJ == LINE_LS_J);
                     end else begin
                        count <= count + 1'b1;
                     end
                  end else begin
                     state  <= PS_DISCONNECTED;
                     count  <= '0;
                     speedJ <= LINE_SE0;
                  end
               end
               PS_ATTACHED: begin
                  if (port_enable_req) begin
                     state     <= PS_PORT_RESET;
                     count     <= '0;
                     drive_se0 <= 1'b1;
                  end
               end
               PS_PORT_RESET: begin
                  if (count == RESET_LAST) begin
                     state     <= PS_RECOVERY;
                     count     <= '0;
                     drive_se0 <= 1'b0;
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               PS_RECOVERY: begin
                  if (count == RECOVERY_LAST) begin
                     count <= '0;
                     if (usb_signals == speedJ) begin
                        state        <= PS_ENABLED;
                        port_enabled <= 1'b1;
                        reset_done   <= 1'b1;
                     end else begin
                        state     <= PS_DISCONNECTED;
                        speedJ    <= LINE_SE0;
                        connected <= 1'b0;
                        low_speed <= 1'b0;
                     end
                  end else begin
                     count <= count + 1'b1;
                  end
               end
               PS_ENABLED: begin
                  if (port_disable_req) begin
                     state        <= PS_ATTACHED;
                     count        <= '0;
                     port_enabled <= 1'b0;
                  end else if (port_enable_req) begin
                     state        <= PS_PORT_RESET;
                     count        <= '0;
                     port_enabled <= 1'b0;
                     drive_se0    <= 1'b1;
                  end
               end
               default: begin
                  state <= PS_DISCONNECTED;
                  count <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_usb_port_attach_controller.sv
// Directed bench for usb_port_attach_controller with default parameters:
// a vector table for the main flow plus hand-written enable, failure and reset sequences.
module tb_usb_port_attach_controller;

   logic       clock;
   logic       reset;
   logic [1:0] usbSignals;
   logic       portEnableReq;
   logic       portDisableReq;
   logic       driveSe0;
   logic       connected;
   logic       lowSpeed;
   logic       portEnabled;
   logic       resetDone;
   logic [2:0] portState;

   int testsRun;
   int testsFailed;
   int driveHighCycles;
   int resetDonePulses;
   bit monitorOn;

   typedef struct {
      logic [1:0] line;
      logic       enReq;
      logic       disReq;
      int         cycles;
      logic [2:0] expState;
      logic       expDrive;
      logic       expConn;
      logic       expLs;
      logic       expEn;
      logic       expRd;
   } vecT;

   vecT vecs[$];

   usb_port_attach_controller dut (
      .clock            (clock),
      .reset            (reset),
      .usb_signals      (usbSignals),
      .port_enable_req  (portEnableReq),
      .port_disable_req (portDisableReq),
      .drive_se0        (driveSe0),
      .connected        (connected),
      .low_speed        (lowSpeed),
      .port_enabled     (portEnabled),
      .reset_done       (resetDone),
      .port_state       (portState)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Counts output activity on falling edges while a sequence is being observed.
   always @(negedge clock) begin
      if (monitorOn) begin
         if (driveSe0) driveHighCycles++;
         if (resetDone) resetDonePulses++;
      end
   end

   task automatic checkValue(input string name, input int actual, input int expected);
      testsRun++;
      if (actual != expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic checkOutput(input string name, input logic [2:0] st, input logic drv,
                              input logic con, input logic ls, input logic en, input logic rd);
      checkValue({name, " port_state"}, int'(portState), int'(st));
      checkValue({name, " drive_se0"}, int'(driveSe0), int'(drv));
      checkValue({name, " connected"}, int'(connected), int'(con));
      checkValue({name, " low_speed"}, int'(lowSpeed), int'(ls));
      checkValue({name, " port_enabled"}, int'(portEnabled), int'(en));
      checkValue({name, " reset_done"}, int'(resetDone), int'(rd));
   endtask

   task automatic applyStimulus(input logic [1:0] line, input logic en, input logic dis, input int n);
      for (int i = 0; i < n; i++) begin
         usbSignals     = line;
         portEnableReq  = en;
         portDisableReq = dis;
         @(posedge clock);
         #1;
      end
      portEnableReq  = 1'b0;
      portDisableReq = 1'b0;
   endtask

   task automatic resetDut();
      reset          = 1'b1;
      usbSignals     = 2'b00;
      portEnableReq  = 1'b0;
      portDisableReq = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic addVec(input logic [1:0] line, input logic en, input logic dis, input int n,
                         input logic [2:0] st, input logic drv, input logic con,
                         input logic ls, input logic pe, input logic rd);
      vecT v;
      v.line = line; v.enReq = en; v.disReq = dis; v.cycles = n;
      v.expState = st; v.expDrive = drv; v.expConn = con;
      v.expLs = ls; v.expEn = pe; v.expRd = rd;
      vecs.push_back(v);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      monitorOn   = 1'b0;
      driveHighCycles = 0;
      resetDonePulses = 0;

      //     line   en dis  n   st drv con ls en rd
      addVec(2'b00, 0, 0,  3,  0, 0, 0, 0, 0, 0);
      addVec(2'b11, 0, 0,  2,  0, 0, 0, 0, 0, 0);
      addVec(2'b10, 0, 0, 16,  1, 0, 0, 0, 0, 0);
      addVec(2'b10, 0, 0,  1,  2, 0, 1, 0, 0, 0);
      addVec(2'b10, 0, 0,  3,  2, 0, 1, 0, 0, 0);
      addVec(2'b11, 0, 0,  3,  2, 0, 1, 0, 0, 0);
      addVec(2'b00, 0, 0,  3,  2, 0, 1, 0, 0, 0);
      addVec(2'b10, 0, 0,  1,  2, 0, 1, 0, 0, 0);
      addVec(2'b00, 0, 0,  3,  2, 0, 1, 0, 0, 0);
      addVec(2'b00, 0, 0,  1,  0, 0, 0, 0, 0, 0);
      addVec(2'b01, 0, 0,  8,  1, 0, 0, 0, 0, 0);
      addVec(2'b00, 0, 0,  1,  0, 0, 0, 0, 0, 0);
      addVec(2'b01, 0, 0, 16,  1, 0, 0, 0, 0, 0);
      addVec(2'b01, 0, 0,  1,  2, 0, 1, 1, 0, 0);
      addVec(2'b01, 1, 0,  1,  3, 1, 1, 1, 0, 0);
      addVec(2'b00, 0, 0, 31,  3, 1, 1, 1, 0, 0);
      addVec(2'b00, 0, 0,  1,  4, 0, 1, 1, 0, 0);
      addVec(2'b01, 0, 0,  3,  4, 0, 1, 1, 0, 0);
      addVec(2'b01, 0, 0,  1,  5, 0, 1, 1, 1, 1);
      addVec(2'b01, 0, 0,  1,  5, 0, 1, 1, 1, 0);
      addVec(2'b00, 0, 0,  2,  5, 0, 1, 1, 1, 0);
      addVec(2'b01, 0, 0,  1,  5, 0, 1, 1, 1, 0);
      addVec(2'b10, 0, 0,  2,  5, 0, 1, 1, 1, 0);
      addVec(2'b01, 0, 1,  1,  2, 0, 1, 1, 0, 0);
      addVec(2'b01, 1, 0,  1,  3, 1, 1, 1, 0, 0);
      addVec(2'b00, 0, 0, 32,  4, 0, 1, 1, 0, 0);
      addVec(2'b01, 0, 0,  4,  5, 0, 1, 1, 1, 1);
      addVec(2'b01, 1, 0,  1,  3, 1, 1, 1, 0, 0);
      addVec(2'b11, 0, 0,  5,  3, 1, 1, 1, 0, 0);

      resetDut();
      checkOutput("reset", 3'd0, 0, 0, 0, 0, 0);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].line, vecs[i].enReq, vecs[i].disReq, vecs[i].cycles);
         checkOutput($sformatf("vec%0d", i), vecs[i].expState, vecs[i].expDrive,
                     vecs[i].expConn, vecs[i].expLs, vecs[i].expEn, vecs[i].expRd);
      end

      // FS enable with a counted SE0 window, then EOP tolerance and disconnect beating disable.
      resetDut();
      applyStimulus(2'b10, 0, 0, 17);
      checkOutput("fsAttach", 3'd2, 0, 1, 0, 0, 0);
      driveHighCycles = 0;
      resetDonePulses = 0;
      monitorOn = 1'b1;
      applyStimulus(2'b10, 1, 0, 1);
      applyStimulus(2'b00, 0, 0, 32);
      applyStimulus(2'b10, 0, 0, 4);
      checkOutput("fsEnabled", 3'd5, 0, 1, 0, 1, 1);
      applyStimulus(2'b10, 0, 0, 3);
      monitorOn = 1'b0;
      checkValue("fsDriveSe0Cycles", driveHighCycles, 32);
      checkValue("fsResetDonePulses", resetDonePulses, 1);
      applyStimulus(2'b00, 0, 0, 2);
      applyStimulus(2'b10, 0, 0, 1);
      checkOutput("fsEop", 3'd5, 0, 1, 0, 1, 0);
      applyStimulus(2'b00, 0, 0, 3);
      checkOutput("fsSe0Short", 3'd5, 0, 1, 0, 1, 0);
      applyStimulus(2'b00, 0, 1, 1);
      checkOutput("fsDisconnectWins", 3'd0, 0, 0, 0, 0, 0);

      // Failed recovery: the line stays at SE0 after the reset window.
      resetDut();
      applyStimulus(2'b10, 0, 0, 17);
      driveHighCycles = 0;
      resetDonePulses = 0;
      monitorOn = 1'b1;
      applyStimulus(2'b10, 1, 0, 1);
      applyStimulus(2'b00, 0, 0, 32);
      applyStimulus(2'b00, 0, 0, 3);
      checkOutput("failRecovering", 3'd4, 0, 1, 0, 0, 0);
      applyStimulus(2'b00, 0, 0, 1);
      checkOutput("failRecoveryEnd", 3'd0, 0, 0, 0, 0, 0);
      applyStimulus(2'b00, 0, 0, 2);
      monitorOn = 1'b0;
      checkValue("failResetDonePulses", resetDonePulses, 0);
      checkValue("failDriveSe0Cycles", driveHighCycles, 32);

      // Asynchronous reset in the middle of PORT_RESET must release drive_se0 without a clock edge.
      resetDut();
      applyStimulus(2'b10, 0, 0, 17);
      applyStimulus(2'b10, 1, 0, 1);
      applyStimulus(2'b00, 0, 0, 10);
      checkOutput("midPortReset", 3'd3, 1, 1, 0, 0, 0);
      #3;
      reset = 1'b1;
      #1;
      checkOutput("asyncReset", 3'd0, 0, 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
      applyStimulus(2'b00, 0, 0, 2);
      checkOutput("afterAsyncReset", 3'd0, 0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
